data_mem_access: RTL
====================

Name: data_mem_access

Overview:
- MEM-stage consumer of the decoder's memory controls: `Mem_read`, `Mem_write` and the 5-bit `Size_control`.
- Turns a sized load or store into word-wide accesses on a synchronous data memory:
  - byte/halfword lane selection and write byte enables
  - sign or zero extension of load data
  - alignment checking
- Stalls the pipeline while an access is in flight.

Parameters:
- ABITS, 10, word-address width of the data memory (memory depth is 2^ABITS words).
- DBITS, 32, data width; only 32 is supported.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_valid  in  1  an instruction is present in the MEM stage.
- i_Mem_read  in  1  load request (from controller).
- i_Mem_write  in  1  store request (from controller).
- i_Size_control  in  5  [4:3] load size (01 byte, 10 half, 11 word); [2] sign-extend; [1:0] store size (01 byte, 10 half, 11 word).
- i_addr  in  32  byte address (ALU result).
- i_wdata  in  32  store data (rt).
- o_stall  out  1  hold all earlier stages and the MEM stage.
- o_done  out  1  one-cycle pulse when the access completes.
- o_rdata  out  32  extended load result; holds its value between loads.
- o_access_err  out  1  pulses with o_done on a misaligned or invalid-size access.
- o_mem_addr  out  ABITS  word address, i_addr[ABITS+1:2].
- o_mem_re  out  1  memory read strobe.
- o_mem_we  out  1  memory write strobe.
- o_mem_be  out  4  write byte enables.
- o_mem_wdata  out  32  lane-replicated write data.
- i_mem_rdata  in  32  memory read data, valid the cycle after o_mem_re.

Behaviour:
- Reset (i_reset=0 at a clock edge):
  - state goes to IDLE; the request latches and all outputs clear to 0, including o_rdata.
  - An in-flight access is aborted: no o_done, read data is discarded, strobes are low from the next cycle.
- States: IDLE, RD_REQ, RD_WAIT, WR, DONE.
- IDLE: request = i_valid & (i_Mem_read | i_Mem_write).
  - On a request, latch address, size, sign and store data.
  - o_stall is combinationally 1 in this cycle.
  - Mem_read has priority if both strobes are set.
  - Error case: misaligned access (half with addr[0]≠0, word with addr[1:0]≠0) or size field 00:
    - no memory strobe is issued; go to DONE with the error flag set.
  - Otherwise a load goes to RD_REQ and a store goes to WR.
- RD_REQ: o_mem_re=1, o_mem_addr=latched word address, o_stall=1; next state RD_WAIT.
- RD_WAIT: o_stall=1.
  - Select the lane from i_mem_rdata (little-endian).
    - Byte k = addr[1:0]: bits [8k+7:8k].
    - Half h = addr[1]: bits [16h+15:16h].
  - Extend per the latched sign bit and register the result into o_rdata; next state DONE.
- WR: o_mem_we=1, o_done=1, o_stall=0; next state IDLE.
  - Byte: be = 0001<<addr[1:0], wdata = {4{rt[7:0]}}.
  - Half: be = 0011<<(2*addr[1]), wdata = {2{rt[15:0]}}.
  - Word: be = 1111, wdata = rt.
- DONE: o_done=1, o_stall=0, o_access_err = latched error flag; next state IDLE.
- In WR and DONE the inputs are ignored: the completing instruction is still presented and must not be re-accepted.
- Latency: load complete in N+3, store complete in N+1, error complete in N+1, where N is the accept cycle.
- Memory strobes and be are 0 in every state other than those listed above.
- Back-to-back accesses cost one IDLE cycle between them.
- A request with i_valid=0 is never accepted.

Test Plan:
- Memory word 4 = 0x8081F2A4:
  - lb at i_addr 0x13 (Size 01100): o_mem_re=1 with o_mem_addr=4 at N+1; o_done and o_rdata=0xFFFFFF80 at N+3; o_stall=1 for N..N+2.
  - lbu at 0x12 (01000): o_rdata=0x00000081.
- Same word:
  - lh at 0x10 (10100): o_rdata=0xFFFFF2A4.
  - lhu at 0x12 (10000): o_rdata=0x00008081.
  - lw at 0x10 (11100): o_rdata=0x8081F2A4.
  - lwu at 0x10 (11000): o_rdata=0x8081F2A4.
- sb at 0x11 with rt=0x123456AB (00001): at N+1 o_mem_we=1, be=0010, wdata=0xABABABAB, o_mem_addr=4, o_done=1; o_stall high only at N.
- sh at 0x11 (00010): no we/re in any cycle; o_done=1 and o_access_err=1 at N+1. sw at 0x12 behaves the same way.
- lw accepted and held stalled: at N+3 the same instruction is still presented, yet there is no second o_mem_re; a new lw applied at N+4 is accepted.
- Reset low during RD_WAIT: next cycle state IDLE, o_done stays 0, o_rdata=0, o_stall=0.

Source files
------------

// File: rtl/data_mem_access_if.sv
// Bus bundle between the MEM stage, the access unit and the data memory.
// Signal names carry the direction as seen from the access unit (slave side).
interface data_mem_access_if #(
  parameter int ABITS = 10,
  parameter int DBITS = 32
);
  // pipeline side
  logic             i_valid;
  logic             i_Mem_read;
  logic             i_Mem_write;
  logic [4:0]       i_Size_control;
  logic [31:0]      i_addr;
  logic [DBITS-1:0] i_wdata;
  logic             o_stall;
  logic             o_done;
  logic [DBITS-1:0] o_rdata;
  logic             o_access_err;
  // memory side
  logic [ABITS-1:0] o_mem_addr;
  logic             o_mem_re;
  logic             o_mem_we;
  logic [3:0]       o_mem_be;
  logic [DBITS-1:0] o_mem_wdata;
  logic [DBITS-1:0] i_mem_rdata;
  // debug view of the access FSM state
  logic [2:0]       o_dbg_state;

  // Handshake: a request is taken only in IDLE when i_valid and a strobe are
  // high; o_stall holds the stage until o_done pulses for that request.
  modport slave (
    input  i_valid, i_Mem_read, i_Mem_write, i_Size_control, i_addr, i_wdata,
    input  i_mem_rdata,
    output o_stall, o_done, o_rdata, o_access_err,
    output o_mem_addr, o_mem_re, o_mem_we, o_mem_be, o_mem_wdata,
    output o_dbg_state
  );

  modport master (
    output i_valid, i_Mem_read, i_Mem_write, i_Size_control, i_addr, i_wdata,
    output i_mem_rdata,
    input  o_stall, o_done, o_rdata, o_access_err,
    input  o_mem_addr, o_mem_re, o_mem_we, o_mem_be, o_mem_wdata,
    input  o_dbg_state
  );
endinterface

// File: rtl/data_mem_access.sv
// MEM-stage data memory access unit: sized loads/stores on a word-wide
// synchronous memory with lane selection, extension and alignment checks.
module data_mem_access #(
  parameter int ABITS = 10,
  parameter int DBITS = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  data_mem_access_if.slave       bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR      = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ABITS+1:0]  r_addr;
  logic [1:0]        r_size;
  logic              r_sign;
  logic [DBITS-1:0]  r_wdata;
  logic              r_err;
  logic [DBITS-1:0]  r_rdata;

  logic              w_req;
  logic [1:0]        w_size;
  logic              w_err;
  logic [DBITS-1:0]  w_byte_sh;
  logic [DBITS-1:0]  w_half_sh;
  logic [DBITS-1:0]  w_ext;
  logic [3:0]        w_be;
  logic [DBITS-1:0]  w_wdata_rep;
  logic              w_unused_addr;

  // Address bits above the memory window do not take part in the access.
  assign w_unused_addr = ^bus.i_addr[31:ABITS+2];

  // Request decode: read wins over write, size comes from the matching field.
  always_comb begin
    w_req  = bus.i_valid & (bus.i_Mem_read | bus.i_Mem_write);
    w_size = bus.i_Mem_read ? bus.i_Size_control[4:3] : bus.i_Size_control[1:0];
    w_err  = (w_size == 2'b00)
           | ((w_size == 2'b10) & bus.i_addr[0])
           | ((w_size == 2'b11) & (|bus.i_addr[1:0]));
  end

  // Load lane select (little-endian) and sign/zero extension.
  always_comb begin
    w_byte_sh = bus.i_mem_rdata >> {r_addr[1:0], 3'b000};
    w_half_sh = bus.i_mem_rdata >> {r_addr[1], 4'b0000};
    case (r_size)
      2'b01:   w_ext = {{24{r_sign & w_byte_sh[7]}}, w_byte_sh[7:0]};
      2'b10:   w_ext = {{16{r_sign & w_half_sh[15]}}, w_half_sh[15:0]};
      default: w_ext = bus.i_mem_rdata;
    endcase
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    case (r_size)
      2'b01: begin
        w_be        = 4'b0001 << r_addr[1:0];
        w_wdata_rep = {4{r_wdata[7:0]}};
      end
      2'b10: begin
        w_be        = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{r_wdata[15:0]}};
      end
      2'b11: begin
        w_be        = 4'b1111;
        w_wdata_rep = r_wdata;
      end
      default: begin
        w_be        = 4'b0000;
        w_wdata_rep = r_wdata;
      end
    endcase
  end

  // State register, request latches and the registered load result.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_size  <= '0;
      r_sign  <= 1'b0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && w_req) begin
        r_addr  <= bus.i_addr[ABITS+1:0];
        r_size  <= w_size;
        r_sign  <= bus.i_Size_control[2];
        r_wdata <= bus.i_wdata;
        r_err   <= w_err;
      end
      if (r_state == S_RD_WAIT) begin
        r_rdata <= w_ext;
      end
    end
  end

  // Next state and per-state outputs; WR and DONE ignore the pipeline inputs
  // so the completing instruction is not taken a second time.
  always_comb begin
    w_next           = r_state;
    bus.o_stall      = 1'b0;
    bus.o_done       = 1'b0;
    bus.o_access_err = 1'b0;
    bus.o_mem_re     = 1'b0;
    bus.o_mem_we     = 1'b0;
    bus.o_mem_be     = 4'b0000;
    bus.o_mem_wdata  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          bus.o_stall = 1'b1;
          if (w_err)                w_next = S_DONE;
          else if (bus.i_Mem_read)  w_next = S_RD_REQ;
          else                      w_next = S_WR;
        end
      end
      S_RD_REQ: begin
        bus.o_stall  = 1'b1;
        bus.o_mem_re = 1'b1;
        w_next       = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        bus.o_stall = 1'b1;
        w_next      = S_DONE;
      end
      S_WR: begin
        bus.o_mem_we    = 1'b1;
        bus.o_mem_be    = w_be;
        bus.o_mem_wdata = w_wdata_rep;
        bus.o_done      = 1'b1;
        w_next          = S_IDLE;
      end
      S_DONE: begin
        bus.o_done       = 1'b1;
        bus.o_access_err = r_err;
        w_next           = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign bus.o_rdata     = r_rdata;
  assign bus.o_mem_addr  = r_addr[ABITS+1:2];
  assign bus.o_dbg_state = r_state;

endmodule
